// File: rtl/snake_pkg.sv
// Shared types and constants for the snake control block.
// State encoding, direction codes, default sizes and the reverse-direction test.
package snake_pkg;

    localparam int unsigned DEF_INIT_LEN = 4;
    localparam int unsigned DEF_MAX_LEN  = 64;
    localparam int unsigned DEF_ADDR_W   = 11;

    // Default head position written by the datapath while seeding.
    localparam logic [7:0] DEF_X = 8'd80;
    localparam logic [6:0] DEF_Y = 7'd60;

    // [2]=vertical axis; vertical uses [1] (1: y+1), horizontal uses [0] (1: x+1).
    localparam logic [2:0] DIR_UP    = 3'b100;
    localparam logic [2:0] DIR_DOWN  = 3'b110;
    localparam logic [2:0] DIR_LEFT  = 3'b000;
    localparam logic [2:0] DIR_RIGHT = 3'b001;

    typedef enum logic [4:0] {
        S_IDLE,
        S_SEED_RST,
        S_SEED,
        S_DI_RST,
        S_DI_RD,
        S_DI_DRAW,
        S_WAIT,
        S_MOVE,
        S_UPD,
        S_SH_RD,
        S_SH_LATCH,
        S_SH_WR,
        S_APPEND,
        S_ERASE,
        S_HD_RST,
        S_HD_RD,
        S_HD_DRAW,
        S_DEAD
    } state_e;

    // Same axis but opposite sign means the snake would turn into itself.
    function automatic logic is_reverse(
        input logic [2:0] cur,
        input logic [2:0] req
    );
        if (cur[2] != req[2]) begin
            return 1'b0;
        end
        return cur[2] ? (cur[1] != req[1]) : (cur[0] != req[0]);
    endfunction

endpackage

// File: rtl/snake_draw_cnt.sv
// Two-bit sub-cell counter shared by all draw states of snake_control.
// Ports: clk, rst (async active-low), en_i, cnt_o (sub-cell index), done_o (last sub-cell).
module snake_draw_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [1:0] cnt_o,
    output logic       done_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Wraps to 0 after the 4th sub-cell, and sits at 0 outside draw states.
    always_comb begin
        cnt_d = 2'd0;
        if (en_i) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = en_i && (cnt_q == 2'd3);

endmodule

// File: rtl/snake_control.sv
// Sequencer for the snake datapath: seed body, then per tick move, shift, check, erase/grow, draw.
// Ports: clk, rst (async active-low), go, tick, dir_in, grow, isDead in; datapath strobes,
// cnt_status, dir, colour, busy, dead, length out.
module snake_control
    import snake_pkg::*;
#(
    parameter int unsigned INIT_LEN = DEF_INIT_LEN,
    parameter int unsigned MAX_LEN  = DEF_MAX_LEN,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              tick,
    input  logic [2:0]        dir_in,
    input  logic              grow,
    input  logic              isDead,
    output logic              ld_head,
    output logic              ld_q_def,
    output logic              inc_address,
    output logic              rst_address,
    output logic              draw_q,
    output logic              update_head,
    output logic              ld_head_into_prev,
    output logic              ld_q_into_curr,
    output logic              ld_prev_into_q,
    output logic              ld_curr_into_prev,
    output logic              draw_curr,
    output logic [1:0]        cnt_status,
    output logic [2:0]        dir,
    output logic              colour,
    output logic              busy,
    output logic              dead,
    output logic [ADDR_W-1:0] length
);

    localparam logic [ADDR_W-1:0] LEN_INIT = ADDR_W'(INIT_LEN);
    localparam logic [ADDR_W-1:0] LEN_MAX  = ADDR_W'(MAX_LEN);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        dir_q, dir_d;
    logic              grow_q, grow_d;

    logic draw_en;
    logic draw_done;
    logic last_addr;

    assign draw_en = (state_q == S_DI_DRAW)
                  || (state_q == S_ERASE)
                  || (state_q == S_HD_DRAW);

    snake_draw_cnt u_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (draw_en),
        .cnt_o  (cnt_status),
        .done_o (draw_done)
    );

    // Mirror of the RAM address register; loops end on the last body slot.
    assign last_addr = (addr_q == len_q - ONE);

    always_comb begin
        state_d           = state_q;
        len_d             = len_q;
        dir_d             = dir_q;
        grow_d            = grow_q;
        ld_head           = 1'b0;
        ld_q_def          = 1'b0;
        inc_address       = 1'b0;
        rst_address       = 1'b0;
        draw_q            = 1'b0;
        update_head       = 1'b0;
        ld_head_into_prev = 1'b0;
        ld_q_into_curr    = 1'b0;
        ld_prev_into_q    = 1'b0;
        ld_curr_into_prev = 1'b0;
        draw_curr         = 1'b0;
        colour            = 1'b1;

        unique case (state_q)
            S_IDLE, S_DEAD: begin
                if (go) begin
                    state_d = S_SEED_RST;
                    len_d   = LEN_INIT;
                    dir_d   = DIR_UP;
                    grow_d  = 1'b0;
                end
            end
            S_SEED_RST: begin
                rst_address = 1'b1;
                state_d     = S_SEED;
            end
            S_SEED: begin
                ld_q_def    = 1'b1;
                inc_address = 1'b1;
                if (last_addr) begin
                    ld_head = 1'b1;
                    state_d = S_DI_RST;
                end
            end
            S_DI_RST: begin
                rst_address = 1'b1;
                state_d     = S_DI_RD;
            end
            S_DI_RD: begin
                state_d = S_DI_DRAW;
            end
            S_DI_DRAW: begin
                draw_q = 1'b1;
                if (draw_done) begin
                    inc_address = 1'b1;
                    state_d = last_addr ? S_WAIT : S_DI_RD;
                end
            end
            S_WAIT: begin
                grow_d = grow_q | grow;
                if (tick) begin
                    state_d = S_MOVE;
                    if (!is_reverse(dir_q, dir_in)) begin
                        dir_d = dir_in;
                    end
                end
            end
            S_MOVE: begin
                ld_head_into_prev = 1'b1;
                rst_address       = 1'b1;
                state_d           = S_UPD;
            end
            S_UPD: begin
                update_head = 1'b1;
                state_d     = S_SH_RD;
            end
            S_SH_RD: begin
                state_d = S_SH_LATCH;
            end
            S_SH_LATCH: begin
                ld_q_into_curr = 1'b1;
                state_d = isDead ? S_DEAD : S_SH_WR;
            end
            S_SH_WR: begin
                // RAM write uses prev/address as they were before this edge.
                ld_prev_into_q    = 1'b1;
                ld_curr_into_prev = 1'b1;
                inc_address       = 1'b1;
                if (!last_addr) begin
                    state_d = S_SH_RD;
                end else if (grow_q && (len_q < LEN_MAX)) begin
                    state_d = S_APPEND;
                end else begin
                    state_d = S_ERASE;
                end
            end
            S_APPEND: begin
                // Old tail stays; written one slot past the previous end.
                ld_prev_into_q = 1'b1;
                len_d          = len_q + ONE;
                grow_d         = 1'b0;
                state_d        = S_HD_RST;
            end
            S_ERASE: begin
                colour    = 1'b0;
                draw_curr = 1'b1;
                if (draw_done) begin
                    state_d = S_HD_RST;
                end
            end
            S_HD_RST: begin
                rst_address = 1'b1;
                state_d     = S_HD_RD;
            end
            S_HD_RD: begin
                state_d = S_HD_DRAW;
            end
            S_HD_DRAW: begin
                draw_q = 1'b1;
                if (draw_done) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        if (rst_address) begin
            addr_d = '0;
        end else if (inc_address) begin
            addr_d = addr_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= LEN_INIT;
            addr_q  <= '0;
            dir_q   <= DIR_UP;
            grow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            grow_q  <= grow_d;
        end
    end

    assign dir    = dir_q;
    assign length = len_q;
    assign dead   = (state_q == S_DEAD);
    assign busy   = (state_q != S_IDLE)
                 && (state_q != S_WAIT)
                 && (state_q != S_DEAD);

endmodule

// File: tb/tb_snake_control.sv
// Testbench for snake_control: per-cycle strobe traces from a frame-level model.
// Table of direction/grow frames, hand corner cases, then randomized frames.
module tb_snake_control;

    localparam int INIT = 4;
    localparam int MAXL = 7;
    localparam int AW   = 11;

    localparam logic [15:0] LDH  = 16'h8000;
    localparam logic [15:0] QDEF = 16'h4000;
    localparam logic [15:0] INC  = 16'h2000;
    localparam logic [15:0] RA   = 16'h1000;
    localparam logic [15:0] DQ   = 16'h0800;
    localparam logic [15:0] UPD  = 16'h0400;
    localparam logic [15:0] HIP  = 16'h0200;
    localparam logic [15:0] QIC  = 16'h0100;
    localparam logic [15:0] PIQ  = 16'h0080;
    localparam logic [15:0] CIP  = 16'h0040;
    localparam logic [15:0] DC   = 16'h0020;
    localparam logic [15:0] C    = 16'h0004;
    localparam logic [15:0] B    = 16'h0002;
    localparam logic [15:0] DD   = 16'h0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic go = 1'b0;
    logic tick = 1'b0;
    logic grow = 1'b0;
    logic isDead = 1'b0;
    logic [2:0] dir_in = 3'b100;

    logic ld_head, ld_q_def, inc_address, rst_address, draw_q;
    logic update_head, ld_head_into_prev, ld_q_into_curr;
    logic ld_prev_into_q, ld_curr_into_prev, draw_curr;
    logic [1:0] cnt_status;
    logic [2:0] dir;
    logic colour, busy, dead;
    logic [AW-1:0] length;
    logic [15:0] obs;

    snake_control #(
        .INIT_LEN (INIT),
        .MAX_LEN  (MAXL),
        .ADDR_W   (AW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .go                (go),
        .tick              (tick),
        .dir_in            (dir_in),
        .grow              (grow),
        .isDead            (isDead),
        .ld_head           (ld_head),
        .ld_q_def          (ld_q_def),
        .inc_address       (inc_address),
        .rst_address       (rst_address),
        .draw_q            (draw_q),
        .update_head       (update_head),
        .ld_head_into_prev (ld_head_into_prev),
        .ld_q_into_curr    (ld_q_into_curr),
        .ld_prev_into_q    (ld_prev_into_q),
        .ld_curr_into_prev (ld_curr_into_prev),
        .draw_curr         (draw_curr),
        .cnt_status        (cnt_status),
        .dir               (dir),
        .colour            (colour),
        .busy              (busy),
        .dead              (dead),
        .length            (length)
    );

    assign obs = {ld_head, ld_q_def, inc_address, rst_address,
                  draw_q, update_head, ld_head_into_prev,
                  ld_q_into_curr, ld_prev_into_q,
                  ld_curr_into_prev, draw_curr, cnt_status,
                  colour, busy, dead};

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] v;
        bit          kill;
        string       tag;
    } exp_t;

    typedef struct {
        logic [2:0] din;
        bit         g;
        logic [2:0] xdir;
        int         xlen;
    } row_t;

    exp_t exp_q[$];
    row_t tbl[8];
    int n_vec = 0;
    int n_err = 0;
    int m_len;
    logic [2:0] m_dir;
    bit m_grow;
    bit m_dead;
    bit noise = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] xp);
        n_vec++;
        if (act !== xp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, xp, $time);
        end
    endtask

    task automatic push(logic [15:0] v, string t, bit k = 1'b0);
        exp_t e;
        e.v = v;
        e.kill = k;
        e.tag = t;
        exp_q.push_back(e);
    endtask

    // Direction as a unit step; reverse means the two steps cancel.
    function automatic void step_of(input logic [2:0] d,
                                    output int dx, output int dy);
        dx = d[2] ? 0 : (d[0] ? 1 : -1);
        dy = d[2] ? (d[1] ? 1 : -1) : 0;
    endfunction

    function automatic bit reverses(logic [2:0] a, logic [2:0] b);
        int ax, ay, bx, by;
        step_of(a, ax, ay);
        step_of(b, bx, by);
        return (ax + bx == 0) && (ay + by == 0);
    endfunction

    function automatic logic [15:0] cnt(int k);
        return 16'(k) << 3;
    endfunction

    task automatic m_reset();
        m_len = INIT;
        m_dir = 3'b100;
        m_grow = 1'b0;
        m_dead = 1'b0;
    endtask

    // Apply queued expectations one cycle at a time, sampled on negedge.
    task automatic run_expect(int limit);
        exp_t e;
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            e = exp_q.pop_front();
            @(negedge clk);
            chk(e.tag, obs, e.v);
            if (noise && e.v[1]) begin
                tick = 1'($urandom);
                go = 1'($urandom);
                grow = 1'($urandom);
            end else begin
                tick = 1'b0;
                go = 1'b0;
                grow = 1'b0;
            end
            if (e.kill) isDead = 1'b1;
            else if (noise && e.v[1] && !e.v[8]) isDead = 1'($urandom);
            else isDead = 1'b0;
            n++;
        end
    endtask

    task automatic seed();
        m_reset();
        go = 1'b1;
        push(RA | B | C, "seed_rst");
        for (int i = 0; i < INIT; i++)
            push(QDEF | INC | B | C | ((i == INIT - 1) ? LDH : 16'h0), "seed");
        push(RA | B | C, "di_rst");
        for (int i = 0; i < INIT; i++) begin
            push(B | C, "di_rd");
            for (int k = 0; k < 4; k++)
                push(DQ | cnt(k) | B | C | ((k == 3) ? INC : 16'h0), "di_draw");
        end
        push(C, "wait");
        run_expect(1000);
        chk("seed_len", length, INIT);
        chk("seed_dir", dir, 3'b100);
    endtask

    task automatic start_frame(logic [2:0] din, bit g, int kill_at);
        dir_in = din;
        grow = g;
        tick = 1'b1;
        if (!reverses(m_dir, din)) m_dir = din;
        m_grow = m_grow | g;
        push(HIP | RA | B | C, "move");
        push(UPD | B | C, "update");
        for (int i = 0; i < m_len; i++) begin
            push(B | C, "sh_rd");
            push(QIC | B | C, "latch", i == kill_at);
            if (i == kill_at) begin
                push(C | DD, "dead");
                m_dead = 1'b1;
                return;
            end
            push(PIQ | CIP | INC | B | C, "wr");
        end
        if (m_grow && m_len < MAXL) begin
            push(PIQ | B | C, "append");
            m_len++;
            m_grow = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) push(DC | cnt(k) | B, "erase");
        end
        push(RA | B | C, "hd_rst");
        push(B | C, "hd_rd");
        for (int k = 0; k < 4; k++) push(DQ | cnt(k) | B | C, "head");
        push(C, "wait");
    endtask

    task automatic frame(logic [2:0] din, bit g, int kill_at);
        start_frame(din, g, kill_at);
        run_expect(2000);
        chk("frame_len", length, m_len);
        chk("frame_dir", dir, m_dir);
        chk("frame_dead", dead, m_dead);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'b110, 1'b0, 3'b100, 4};
        tbl[1] = '{3'b001, 1'b1, 3'b001, 5};
        tbl[2] = '{3'b000, 1'b0, 3'b001, 5};
        tbl[3] = '{3'b110, 1'b1, 3'b110, 6};
        tbl[4] = '{3'b100, 1'b0, 3'b110, 6};
        tbl[5] = '{3'b000, 1'b0, 3'b000, 6};
        tbl[6] = '{3'b001, 1'b1, 3'b000, 7};
        tbl[7] = '{3'b100, 1'b0, 3'b100, 7};
        m_reset();

        #12;
        chk("rst_vec", obs, C);
        chk("rst_dir", dir, 3'b100);
        chk("rst_len", length, INIT);
        chk("rst_dead", dead, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle", obs, C);
        seed();

        noise = 1'b1;
        for (int i = 0; i < 8; i++) begin
            frame(tbl[i].din, tbl[i].g, -1);
            chk("tbl_dir", dir, tbl[i].xdir);
            chk("tbl_len", length, tbl[i].xlen);
        end

        frame(3'b100, 1'b1, -1);
        chk("max_len_hold", length, MAXL);

        frame(3'b000, 1'b0, 2);
        chk("dead_flag", dead, 1'b1);
        chk("dead_busy", busy, 1'b0);
        tick = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("dead_hold", obs, C | DD);
        end
        tick = 1'b0;
        seed();

        frame(3'b001, 1'b1, -1);
        chk("pre_rst_len", length, 5);
        start_frame(3'b110, 1'b0, -1);
        run_expect(7);
        exp_q.delete();
        #2;
        rst = 1'b0;
        tick = 1'b0;
        go = 1'b0;
        grow = 1'b0;
        isDead = 1'b0;
        #1;
        chk("midrst_vec", obs, C);
        chk("midrst_len", length, INIT);
        chk("midrst_dir", dir, 3'b100);
        chk("midrst_cnt", cnt_status, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_idle", obs, C);
        seed();

        for (int r = 0; r < 40; r++) begin
            logic [2:0] d;
            bit g;
            int ka;
            d = 3'($urandom);
            g = ($urandom_range(3) == 0);
            ka = ($urandom_range(7) == 0) ? int'($urandom_range(m_len - 1)) : -1;
            frame(d, g, ka);
            if (m_dead) seed();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
